stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//   Consumer of the debounced button events: a start/stop/clear stopwatch controller.
//   Takes single-cycle event pulses from the button debouncers and counts elapsed time as
//   BCD digits SS.CC (seconds, centiseconds). Generates the debouncer sample strobe
//   (smp_tick), which is wired to each debouncer's rtg_btn input.
// PARAMETERS
//   PRESCALE  500000  clk cycles per centisecond (50 MHz clk); legal range >= 2
//   SMP_DIV   250000  clk cycles per smp_tick pulse (5 ms at 50 MHz); legal range >= 2
// PORTS
//   clk             in   1   system clock; all logic on posedge
//   rst_n           in   1   asynchronous, active-low reset
//   start_stop_evt  in   1   1-cycle pulse from start/stop debouncer
//   clear_evt       in   1   1-cycle pulse from clear debouncer
//   smp_tick        out  1   1-cycle strobe every SMP_DIV clks, drives debouncer rtg_btn
//   running         out  1   1 while in RUN
//   bcd_out         out  16  {sec_tens, sec_ones, cs_tens, cs_ones}, 4-bit BCD each
//   wrap            out  1   1-cycle pulse when count rolls 59.99 -> 00.00
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE; bcd_out=16'h0000; running=0; wrap=0; smp_tick=0.
//     Prescaler and smp divider are cleared. Reset mid-count discards the count immediately.
//   smp_tick: divider counts 0..SMP_DIV-1 freely in every state.
//     smp_tick is registered and is 1 on the cycle after the divider reaches SMP_DIV-1.
//     First pulse: SMP_DIV cycles after reset release.
//   FSM states: IDLE (count 00.00), RUN, PAUSE. Events are sampled on the same posedge.
//     IDLE : start_stop -> RUN; clear -> stay in IDLE (no-op).
//     RUN  : start_stop -> PAUSE; clear is ignored.
//     PAUSE: clear -> IDLE (count and prescaler zeroed); start_stop alone -> RUN.
//   Simultaneous events: IDLE -> RUN; RUN -> PAUSE; PAUSE -> IDLE (clear wins).
//   running is registered and equals (state==RUN) one cycle after the transition edge.
//   Prescaler: counts 0..PRESCALE-1 only in RUN. In PAUSE it holds its value, so a resume
//     keeps the sub-centisecond phase. It is zeroed in IDLE.
//   Increment: when the prescaler equals PRESCALE-1 in RUN, the prescaler returns to 0.
//     On that same edge, bcd_out increments by 0.01 s.
//     From IDLE, the first increment occurs PRESCALE cycles after the RUN-entry edge.
//   BCD rules: cs_ones 9->0 carries into cs_tens; cs_tens 9->0 carries into sec_ones.
//     sec_ones 9->0 carries into sec_tens; sec_tens 5->0 at 59.99.
//     At 59.99 the count wraps to 00.00, wrap=1 for exactly that cycle, and state stays RUN.
//     Every digit stays in its legal range at all times (sec_tens 0..5, others 0..9).
//   Stopping on the same edge as an increment: the increment is committed, then PAUSE.
//   Event pulses longer than 1 cycle are treated as repeated events (the debouncer guarantees 1).
// TESTING (bench uses PRESCALE=4, SMP_DIV=3)
//   Reset release, no events, 20 clks -> bcd_out=0000, running=0.
//     smp_tick pulses at clks 3, 6, 9, ...
//   start_stop at t0 -> running=1 from t0+1; bcd_out=0001 at t0+4, 0002 at t0+8.
//     No change between those edges.
//   Run to 00.09, then 1 tick -> 0010; run to 59.99, then 1 tick -> 0000 with wrap=1 for 1 clk.
//     running stays 1 throughout.
//   Pause after 2 prescaler counts, hold 10 clks, resume -> next increment 2 clks after resume.
//     bcd_out is frozen during the pause.
//   clear during RUN -> ignored; clear during PAUSE -> IDLE, 0000.
//     Simultaneous start_stop+clear in PAUSE -> IDLE; in IDLE -> RUN.
//   Assert rst_n=0 asynchronously mid-RUN at 12.34 -> outputs zero without waiting for a clk edge.
//     After release, start_stop is needed to count again.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: start/stop/clear stopwatch counting BCD SS.CC, plus debouncer sample strobe
module stopwatch_ctrl #(
  parameter int PRESCALE = 500000,
  parameter int SMP_DIV  = 250000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_stop_evt,
  input  logic        clear_evt,
  output logic        smp_tick,
  output logic        running,
  output logic [15:0] bcd_out,
  output logic        wrap
);
  localparam int PW = $clog2(PRESCALE);
  localparam int SW = $clog2(SMP_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
  localparam logic [SW-1:0] DIV_MAX = SW'(SMP_DIV - 1);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [SW-1:0] div_q, div_d;
  logic [15:0] bcd_q, bcd_d, bcd_inc;
  logic wrap_q, wrap_d, run_q, run_d, smp_q, smp_d, tc;
  logic [3:0] d0, d1, d2, d3;
  logic c0, c1, c2, c3;
  assign {d3, d2, d1, d0} = bcd_q;
  assign c0 = d0 == 4'd9;
  assign c1 = c0 && d1 == 4'd9;
  assign c2 = c1 && d2 == 4'd9;
  assign c3 = c2 && d3 == 4'd5;
  assign bcd_inc = {c3 ? 4'd0 : c2 ? d3 + 4'd1 : d3,
                    c2 ? 4'd0 : c1 ? d2 + 4'd1 : d2,
                    c1 ? 4'd0 : c0 ? d1 + 4'd1 : d1,
                    c0 ? 4'd0 : d0 + 4'd1};
  assign smp_tick = smp_q;
  assign running  = run_q;
  assign bcd_out  = bcd_q;
  assign wrap     = wrap_q;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  // next state: clear only acts in PAUSE and wins over start_stop there
  always_comb begin
    state_d = state_q == IDLE ? (start_stop_evt ? RUN : IDLE) :
              state_q == RUN  ? (start_stop_evt ? PAUSE : RUN) :
              clear_evt ? IDLE : start_stop_evt ? RUN : PAUSE;
  end
  // datapath next values: prescaler holds in PAUSE so a resume keeps its phase
  always_comb begin
    tc     = state_q == RUN && pre_q == PRE_MAX;
    pre_d  = state_d == IDLE ? '0 : state_q != RUN ? pre_q : tc ? '0 : pre_q + PW'(1);
    bcd_d  = state_d == IDLE ? '0 : tc ? bcd_inc : bcd_q;
    wrap_d = tc && c3;
    run_d  = state_q == RUN;
    div_d  = div_q == DIV_MAX ? '0 : div_q + SW'(1);
    smp_d  = div_q == DIV_MAX;
  end
  // datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pre_q  <= '0;
      div_q  <= '0;
      bcd_q  <= '0;
      wrap_q <= 1'b0;
      run_q  <= 1'b0;
      smp_q  <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      div_q  <= div_d;
      bcd_q  <= bcd_d;
      wrap_q <= wrap_d;
      run_q  <= run_d;
      smp_q  <= smp_d;
    end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: randomized and directed checks of stopwatch_ctrl against a time-based model
module tb_stopwatch_ctrl;
  localparam int PRESCALE = 4;
  localparam int SMP_DIV  = 3;
  logic clk = 1'b0, rst_n = 1'b1, start_stop_evt = 1'b0, clear_evt = 1'b0;
  logic smp_tick, running, wrap;
  logic [15:0] bcd_out;
  int total = 0, bad = 0;
  int m_mode, m_cs, m_phase, m_cyc;
  logic m_running, m_wrap, m_smp;
  stopwatch_ctrl #(.PRESCALE(PRESCALE), .SMP_DIV(SMP_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .start_stop_evt(start_stop_evt), .clear_evt(clear_evt),
    .smp_tick(smp_tick), .running(running), .bcd_out(bcd_out), .wrap(wrap));
  always #5 clk = ~clk;
  function automatic logic [15:0] to_bcd(input int cs);
    int s, c;
    s = cs / 100;
    c = cs % 100;
    return {4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_mode = 0; m_cs = 0; m_phase = 0; m_cyc = 0;
    m_running = 0; m_wrap = 0; m_smp = 0;
  endtask
  // mode: 0 idle, 1 run, 2 pause; time advances in RUN only, PRESCALE clks per centisecond
  task automatic model_step(input logic ev, input logic cl);
    m_running = m_mode == 1;
    m_wrap = 0;
    if (m_mode == 1) begin
      m_phase++;
      if (m_phase == PRESCALE) begin
        m_phase = 0;
        m_cs = (m_cs + 1) % 6000;
        m_wrap = m_cs == 0;
      end
    end
    if (m_mode == 0) begin
      if (ev) m_mode = 1;
    end else if (m_mode == 1) begin
      if (ev) m_mode = 2;
    end else if (cl) begin
      m_mode = 0; m_cs = 0; m_phase = 0;
    end else if (ev) m_mode = 1;
    m_cyc++;
    m_smp = m_cyc % SMP_DIV == 0;
  endtask
  task automatic tick(input logic ev, input logic cl);
    start_stop_evt = ev;
    clear_evt = cl;
    @(posedge clk);
    model_step(ev, cl);
    @(negedge clk);
    start_stop_evt = 1'b0;
    clear_evt = 1'b0;
    check("bcd", bcd_out, to_bcd(m_cs));
    check("running", 16'(running), 16'(m_running));
    check("wrap", 16'(wrap), 16'(m_wrap));
    check("smp_tick", 16'(smp_tick), 16'(m_smp));
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
  endtask
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_bcd", bcd_out, 16'h0000);
    check("rst_running", 16'(running), 16'h0);
    check("rst_wrap", 16'(wrap), 16'h0);
    check("rst_smp", 16'(smp_tick), 16'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    int n, wraps;
    model_reset();
    @(negedge clk);
    async_reset();
    idle(20);
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b0);
    idle(40);
    wraps = 0;
    for (int i = 0; i < 24100; i++) begin
      tick(1'b0, 1'b0);
      if (wrap) wraps++;
    end
    check("wrap_count", 16'(wraps), 16'd1);
    tick(1'b0, 1'b1);
    idle(5);
    while (m_phase != 1) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    idle(10);
    tick(1'b1, 1'b0);
    idle(10);
    tick(1'b1, 1'b0);
    idle(3);
    tick(1'b0, 1'b1);
    idle(3);
    tick(1'b1, 1'b1);
    idle(20);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    idle(5);
    for (int i = 0; i < 3000; i++)
      tick($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
    @(negedge clk);
    async_reset();
    tick(1'b1, 1'b0);
    n = 0;
    while (m_cs != 1234 && n < 10000) begin
      tick(1'b0, 1'b0);
      n++;
    end
    check("reach_1234", bcd_out, 16'h1234);
    async_reset();
    idle(10);
    tick(1'b1, 1'b0);
    idle(12);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
